// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Memory stage that sits directly behind the ALU. The ALU result is used as the
// effective address for LB/LH/LW/LBU/LHU/SB/SH/SW against a word-wide data
// memory with a request/ack handshake. One operation is in flight at a time;
// the core stalls while busy=1.
//
// Lanes are little-endian: byte 0 of a word is bits [7:0].
//
// Ports
//   clk        in   1   clock, all state on the rising edge
//   rst_n      in   1   synchronous active-low reset
//   req_valid  in   1   memory op presented by the datapath
//   req_ready  out  1   op accepted when req_valid & req_ready
//   is_store   in   1   1 = store, 0 = load
//   size       in   2   00 byte, 01 half, 10 word, 11 illegal
//   sign_ext   in   1   loads only: 1 = sign-extend, 0 = zero-extend
//   addr       in   32  effective address
//   wdata      in   32  store data
//   busy       out  1   op in flight
//   done       out  1   one-cycle completion pulse
//   load_data  out  32  extended load result, valid with done, held otherwise
//   align_err  out  1   with done: misaligned or illegal size, no access made
//   bus_err    out  1   with done: no ack within TIMEOUT cycles
//   mem_req    out  1   memory request, held until ack or timeout
//   mem_we     out  1   1 = write
//   mem_be     out  4   byte enables
//   mem_addr   out  32  word-aligned address
//   mem_wdata  out  32  lane-replicated store data
//   mem_rdata  in   32  read word, sampled when mem_ack = 1
//   mem_ack    in   1   completion from memory
//
// Parameters
//   TIMEOUT    cycles mem_req may stay high without mem_ack before bus_err (>=2)
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        is_store,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        align_err,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;

  // Operation captured at accept; held stable for the whole access.
  logic              store_p0;
  logic [1:0]        size_p0;
  logic              sext_p0;
  logic [31:0]       addr_p0;
  logic [31:0]       wdata_p0;

  logic              align_flag;
  logic              bus_flag;

  logic              accept;
  logic              misaligned;
  logic              timeout_hit;
  logic              in_access;

  // ---------------------------------------------------------------------------
  // Lane helpers
  // ---------------------------------------------------------------------------
  function automatic logic [3:0] lane_enables(input logic [1:0] sz,
                                              input logic [1:0] lo);
    logic [3:0] be;
    case (sz)
      SZ_BYTE: be = 4'b0001 << lo;
      SZ_HALF: be = 4'b0011 << {lo[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] replicate_store(input logic [1:0]  sz,
                                                  input logic [31:0] wd);
    logic [31:0] rep;
    case (sz)
      SZ_BYTE: rep = {4{wd[7:0]}};
      SZ_HALF: rep = {2{wd[15:0]}};
      default: rep = wd;
    endcase
    return rep;
  endfunction

  // Shift the addressed lane down to bit 0, then extend to 32 bits.
  function automatic logic [31:0] extract_load(input logic [1:0]  sz,
                                               input logic        sext,
                                               input logic [1:0]  lo,
                                               input logic [31:0] rd);
    logic [31:0]        shifted;
    logic signed [7:0]  lane_b;
    logic signed [15:0] lane_h;
    logic [31:0]        res;
    shifted = rd >> {lo, 3'b000};
    lane_b  = shifted[7:0];
    lane_h  = shifted[15:0];
    case (sz)
      SZ_BYTE: res = sext ? {{24{lane_b[7]}}, lane_b}  : {24'd0, lane_b};
      SZ_HALF: res = sext ? {{16{lane_h[15]}}, lane_h} : {16'd0, lane_h};
      default: res = rd;
    endcase
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Handshake and alignment decode on the incoming op
  // ---------------------------------------------------------------------------
  assign req_ready = rst_n && (state == IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = addr[0];
      SZ_WORD: misaligned = (addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  assign timeout_hit = (cnt == CNT_LAST);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = misaligned ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        // An ack arriving in the final allowed cycle still completes normally.
        if (mem_ack || timeout_hit) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control state: FSM, timeout counter, result flags, load result
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      align_flag <= 1'b0;
      bus_flag   <= 1'b0;
      load_data  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            align_flag <= misaligned;
            bus_flag   <= 1'b0;
            cnt        <= '0;
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            if (!store_p0) begin
              load_data <= extract_load(size_p0, sext_p0, addr_p0[1:0], mem_rdata);
            end
          end else if (timeout_hit) begin
            bus_flag <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Op capture (data path, no reset needed: only observed while in ACCESS)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (accept) begin
      store_p0 <= is_store;
      size_p0  <= size;
      sext_p0  <= sign_ext;
      addr_p0  <= addr;
      wdata_p0 <= wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs; memory side is forced low outside ACCESS so it idles at zero
  // ---------------------------------------------------------------------------
  assign in_access = (state == ACCESS);
  assign busy      = (state != IDLE);
  assign done      = (state == RESP);
  assign align_err = done && align_flag;
  assign bus_err   = done && bus_flag;

  assign mem_req   = in_access;
  assign mem_we    = in_access && store_p0;
  assign mem_be    = in_access ? lane_enables(size_p0, addr_p0[1:0]) : 4'b0000;
  assign mem_addr  = in_access ? {addr_p0[31:2], 2'b00} : 32'd0;
  assign mem_wdata = in_access ? replicate_store(size_p0, wdata_p0) : 32'd0;

endmodule
